adc_driver: RTL and testbench
=============================

Name: adc_driver

Overview:
- SPI master that reads a physical 12-bit serial ADC (MCP3201-style frame: 2 sample clocks, 1 null bit, then B11..B0 MSB-first) at a fixed audio sample rate.
- Delivers each sample left-justified as a 16-bit word with a one-cycle data_ready strobe into the effects chain. This is the capture end of the path that terminates in dac_driver.

Parameters:
- clock_max, 25_000_000, audio_clock frequency in Hz.
- sample_rate, 48_000, conversion rate in Hz; sample_div = clock_max / sample_rate (integer divide, 520 by default).
- sclk_half, 4, audio_clock cycles per SCLK half-period (SCLK = 3.125 MHz by default); must be ≥ 1.
- frame_bits, 15, SCLK rising edges per conversion frame; data is the last 12 bits captured.
- Elaboration check: (2*frame_bits+2)*sclk_half + 2 < sample_div, else $error.

Ports:
- audio_clock  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  permits new conversions; sampled only at tick
- miso_in  in  1  ADC DOUT
- sclk_out  out  1  SPI clock to ADC, idle low
- cs_n_out  out  1  ADC chip select, active low
- data_out  out  16  last sample, {adc[11:0], 4'b0000}
- data_ready  out  1  one-cycle strobe, data_out valid
- active_out  out  1  high while a frame is in progress (state ≠ IDLE)
- overrun_out  out  1  sticky; tick arrived while frame still in progress

Behaviour:
- Reset (async assert, sync release): sclk_out=0, cs_n_out=1, data_out=16'h0000, data_ready=0, active_out=0, overrun_out=0, state IDLE, all counters and shift register 0.
- Tick counter free-runs 0..sample_div-1 regardless of enable. Tick is the cycle where count == sample_div-1. The first tick after reset release is on cycle 519.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD.
- IDLE: on tick with enable=1, go to CS_SETUP and drive cs_n_out=0 at that edge. On tick with enable=0, stay in IDLE with no bus activity.
- CS_SETUP: hold for sclk_half cycles with sclk_out=0, then go to SHIFT.
- SHIFT: runs frame_bits SCLK periods. Each period is sclk_half cycles low, then sclk_half cycles high.
  - miso_in is shifted into the LSB of a 12-bit shift register on the same edge where sclk_out goes 0→1. Earlier bits fall off the MSB, so null and sample bits are discarded automatically.
  - After the high half of the last period, sclk_out returns to 0 and the FSM goes to CS_HOLD.
- CS_HOLD: cs_n_out=1 at entry. After sclk_half cycles:
  - data_out <= {shift[11:0], 4'b0};
  - data_ready=1 for exactly one cycle;
  - return to IDLE.
- Latency: data_ready rises exactly (2*frame_bits+2)*sclk_half + 1 cycles after the tick edge (129 with defaults). Strobe period is exactly sample_div cycles in steady state.
- data_out holds its value between strobes and changes only on the data_ready cycle.
- enable deasserted mid-frame: the current frame completes normally, including its strobe.
- Tick while active_out=1 (only possible if the elaboration check is bypassed): tick is ignored and overrun_out is set. overrun_out clears only on reset.
- Reset asserted mid-frame: cs_n_out high and sclk_out low immediately (asynchronous). No strobe is issued and data_out returns to 0.
- SCLK edge count per frame is exactly frame_bits. cs_n_out is never low while in IDLE.

Test Plan:
- Reset: hold rst_n=0 with miso toggling → all outputs at reset values, no SCLK edges; release → first cs_n_out fall at cycle 519.
- Single conversion: ADC model drives 0,0,null 0 then 12'hA5C MSB-first → exactly 15 SCLK rises while cs_n low; data_out=16'hA5C0; data_ready one cycle, 129 cycles after tick.
- Extremes and garbage lead bits: model drives 1 on the 3 lead bits with data 12'h000, then 12'hFFF → data_out 16'h0000, then 16'hFFF0.
- Periodic streaming with enable=1 for 5 frames → data_ready spacing exactly 520 cycles; overrun_out stays 0.
- Enable gating: enable=0 across a tick → cs_n_out stays 1 and no strobe; drop enable mid-SHIFT → frame completes with a strobe, and no further frames start.
- Reset mid-SHIFT (after the 7th SCLK rise) → cs_n_out=1 and sclk_out=0 asynchronously, no data_ready; after release the next frame decodes correctly.

Source files
------------

// File: rtl/adc_driver.sv
// SPI capture master for a 12-bit MCP3201-style serial ADC.
// Starts one conversion frame per sample tick and presents each result
// left-justified on data_out, along with a one-cycle data_ready strobe.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | chip select high, waiting for a tick with enable set
// CS_SETUP | chip select low, SCLK held low for one half-period
// SHIFT    | frame_bits SCLK periods; MISO is captured on each SCLK rise
// CS_HOLD  | chip select high again; publishes the sample when the hold ends

module adc_driver #(
  parameter int clock_max   = 25_000_000,
  parameter int sample_rate = 48_000,
  parameter int sclk_half   = 4,
  parameter int frame_bits  = 15
) (
  input  logic        audio_clock,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        miso_in,
  output logic        sclk_out,
  output logic        cs_n_out,
  output logic [15:0] data_out,
  output logic        data_ready,
  output logic        active_out,
  output logic        overrun_out
);

  localparam int sample_div = clock_max / sample_rate;
  localparam int tick_w     = $clog2(sample_div);
  localparam int half_w     = $clog2(sclk_half + 1);
  localparam int bit_w      = $clog2(frame_bits + 1);

  localparam logic [tick_w-1:0] tick_last = tick_w'(sample_div - 1);
  localparam logic [half_w-1:0] half_last = half_w'(sclk_half - 1);
  // The hold phase gets one extra cycle, so the strobe comes
  // (2*frame_bits+2)*sclk_half + 1 cycles after the tick.
  localparam logic [half_w-1:0] half_hold = half_w'(sclk_half);
  localparam logic [bit_w-1:0]  bit_last  = bit_w'(frame_bits - 1);

  if (sclk_half < 1) begin : g_bad_sclk_half
    $error("adc_driver: sclk_half must be at least 1");
  end
  if ((2 * frame_bits + 2) * sclk_half + 2 >= sample_div) begin : g_bad_timing
    $error("adc_driver: conversion frame does not fit in one sample period");
  end

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [tick_w-1:0]   tick_cnt;
  logic                tick;
  logic [half_w-1:0]   half_cnt, half_d;
  logic [bit_w-1:0]    bit_cnt, bit_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic [11:0]         shift_q, shift_d;
  logic [15:0]         data_q, data_d;
  logic                ready_q, ready_d;
  logic                overrun_q, overrun_d;

  assign tick = (tick_cnt == tick_last);

  // Free-running sample-rate counter; it keeps counting whether or not enable is set.
  always_ff @(posedge audio_clock or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + tick_w'(1);
    end
  end

  // State register and registered bus outputs.
  always_ff @(posedge audio_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_cnt  <= half_d;
      bit_cnt   <= bit_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic. Every timed phase runs on a half-period down-counter
  // that ends when it reaches zero.
  always_comb begin
    state_d   = state_q;
    half_d    = half_cnt;
    bit_d     = bit_cnt;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    overrun_d = overrun_q;

    // A tick that lands inside a frame is dropped; the overrun flag records it.
    if (tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (tick && enable) begin
          state_d = CS_SETUP;
          cs_n_d  = 1'b0;
          half_d  = half_last;
        end
      end

      CS_SETUP: begin
        if (half_cnt != '0) begin
          half_d = half_cnt - half_w'(1);
        end else begin
          state_d = SHIFT;
          half_d  = half_last;
          bit_d   = bit_last;
        end
      end

      SHIFT: begin
        if (half_cnt != '0) begin
          half_d = half_cnt - half_w'(1);
        end else if (!sclk_q) begin
          // Rising SCLK edge: the ADC has held this bit steady since the previous fall.
          sclk_d  = 1'b1;
          shift_d = {shift_q[10:0], miso_in};
          half_d  = half_last;
        end else begin
          sclk_d = 1'b0;
          half_d = half_last;
          if (bit_cnt == '0) begin
            state_d = CS_HOLD;
            cs_n_d  = 1'b1;
            half_d  = half_hold;
          end else begin
            bit_d = bit_cnt - bit_w'(1);
          end
        end
      end

      CS_HOLD: begin
        if (half_cnt != '0) begin
          half_d = half_cnt - half_w'(1);
        end else begin
          data_d  = {shift_q, 4'b0000};
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sclk_out    = sclk_q;
  assign cs_n_out    = cs_n_q;
  assign data_out    = data_q;
  assign data_ready  = ready_q;
  assign active_out  = (state_q != IDLE);
  assign overrun_out = overrun_q;

endmodule

// File: tb/tb_adc_driver.sv
// Testbench for adc_driver. A behavioural ADC model serves one frame word per
// chip-select fall. A scoreboard queue holds the expected samples, and a
// monitor pops and checks one entry on every data_ready strobe.

module tb_adc_driver;

  logic        audio_clock = 1'b0;
  logic        rst_n       = 1'b0;
  logic        enable      = 1'b0;
  logic        miso_in     = 1'b0;
  logic        sclk_out;
  logic        cs_n_out;
  logic [15:0] data_out;
  logic        data_ready;
  logic        active_out;
  logic        overrun_out;

  adc_driver dut (
    .audio_clock (audio_clock),
    .rst_n       (rst_n),
    .enable      (enable),
    .miso_in     (miso_in),
    .sclk_out    (sclk_out),
    .cs_n_out    (cs_n_out),
    .data_out    (data_out),
    .data_ready  (data_ready),
    .active_out  (active_out),
    .overrun_out (overrun_out)
  );

  always #5 audio_clock = ~audio_clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard queues: ADC frame words {lead[2:0], sample[11:0]} and expected data_out.
  logic [14:0] adc_q[$];
  logic [15:0] exp_q[$];

  int cyc       = 0;
  int since_rel = 0;

  // Edge counters: total edges, and edges since the last reset release.
  always @(posedge audio_clock) begin
    cyc++;
    if (!rst_n) since_rel = 0;
    else        since_rel++;
  end

  // ADC model: first bit appears at the CS fall; each later bit shifts out on an SCLK fall.
  logic [14:0] m_word = '0;
  int          m_idx  = 0;
  logic        m_prev_cs = 1'b1;
  logic        m_prev_sclk = 1'b0;
  always @(negedge audio_clock) begin
    if (!rst_n) begin
      miso_in     = ~miso_in;
      m_prev_cs   = 1'b1;
      m_prev_sclk = 1'b0;
    end else begin
      if (!cs_n_out && m_prev_cs) begin
        m_word  = (adc_q.size() != 0) ? adc_q.pop_front() : 15'h0000;
        m_idx   = 0;
        miso_in = m_word[14];
      end else if (!cs_n_out && m_prev_sclk && !sclk_out) begin
        m_idx++;
        if (m_idx < 15) miso_in = m_word[14 - m_idx];
      end
      m_prev_cs   = cs_n_out;
      m_prev_sclk = sclk_out;
    end
  end

  // Monitor: checks each strobe against the scoreboard, and checks per-cycle invariants.
  int          t_cs          = 0;
  int          rise_cnt      = 0;
  int          cs_falls      = 0;
  int          strobe_cnt    = 0;
  int          last_strobe   = -1;
  int          inv_err       = 0;
  int          reset_rises   = 0;
  bit          first_pending = 1'b1;
  bit          check_spacing = 1'b0;
  logic [15:0] last_data     = '0;
  logic [15:0] exp_v;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_ready = 1'b0;
  always @(negedge audio_clock) begin
    if (!rst_n) begin
      if (sclk_out && !prev_sclk) reset_rises++;
      last_data     = '0;
      last_strobe   = -1;
      first_pending = 1'b1;
    end else begin
      if (!cs_n_out && prev_cs) begin
        cs_falls++;
        t_cs     = cyc;
        rise_cnt = 0;
        if (first_pending) begin
          chk("first_cs_fall_edge", since_rel, 520);
          first_pending = 1'b0;
        end
      end
      if (sclk_out && !prev_sclk && !cs_n_out) rise_cnt++;
      if (data_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", int'(data_ready), 0);
        end else begin
          exp_v = exp_q.pop_front();
          chk("data_out", int'(data_out), int'(exp_v));
          chk("strobe_latency", cyc - t_cs, 129);
          chk("sclk_rises", rise_cnt, 15);
          if (check_spacing && last_strobe >= 0)
            chk("strobe_spacing", cyc - last_strobe, 520);
          last_data = exp_v;
        end
        last_strobe = cyc;
        strobe_cnt++;
      end
      if (data_out !== last_data)     inv_err++;
      if (data_ready && prev_ready)   inv_err++;
      if (!cs_n_out && !active_out)   inv_err++;
      if (sclk_out && cs_n_out)       inv_err++;
    end
    prev_cs    = cs_n_out;
    prev_sclk  = sclk_out;
    prev_ready = data_ready;
  end

  task automatic step();
    @(negedge audio_clock);
    #1;
  endtask

  task automatic wait_strobes(input int n, input int limit, input string name);
    int k = 0;
    while (strobe_cnt < n && k < limit) begin step(); k++; end
    if (strobe_cnt < n) chk(name, strobe_cnt, n);
  endtask

  task automatic wait_falls(input int n, input int limit, input string name);
    int k = 0;
    while (cs_falls < n && k < limit) begin step(); k++; end
    if (cs_falls < n) chk(name, cs_falls, n);
  endtask

  task automatic wait_rises(input int n, input int limit, input string name);
    int k = 0;
    while (rise_cnt < n && k < limit) begin step(); k++; end
    if (rise_cnt < n) chk(name, rise_cnt, n);
  endtask

  int falls0;
  int strobes0;

  initial begin
    enable = 1'b1;
    rst_n  = 1'b0;
    repeat (20) step();
    chk("reset_sclk",    int'(sclk_out),    0);
    chk("reset_cs_n",    int'(cs_n_out),    1);
    chk("reset_data",    int'(data_out),    0);
    chk("reset_ready",   int'(data_ready),  0);
    chk("reset_active",  int'(active_out),  0);
    chk("reset_overrun", int'(overrun_out), 0);
    chk("reset_sclk_edges", reset_rises, 0);

    // Streaming frames: plain data, set lead bits over 000 and FFF, then mixed patterns.
    adc_q.push_back({3'b000, 12'hA5C}); exp_q.push_back(16'hA5C0);
    adc_q.push_back({3'b111, 12'h000}); exp_q.push_back(16'h0000);
    adc_q.push_back({3'b111, 12'hFFF}); exp_q.push_back(16'hFFF0);
    adc_q.push_back({3'b010, 12'h123}); exp_q.push_back(16'h1230);
    adc_q.push_back({3'b101, 12'h800}); exp_q.push_back(16'h8000);
    check_spacing = 1'b1;
    rst_n = 1'b1;
    wait_strobes(5, 520 * 6 + 200, "stream_timeout");
    chk("stream_overrun", int'(overrun_out), 0);

    // A tick with enable low must not start a frame.
    check_spacing = 1'b0;
    enable   = 1'b0;
    falls0   = cs_falls;
    strobes0 = strobe_cnt;
    repeat (600) step();
    chk("gated_cs_falls", cs_falls - falls0, 0);
    chk("gated_strobes",  strobe_cnt - strobes0, 0);
    chk("gated_cs_n",     int'(cs_n_out), 1);

    // Dropping enable in the middle of SHIFT lets the frame finish, and then no new frame starts.
    adc_q.push_back({3'b000, 12'h3C7}); exp_q.push_back(16'h3C70);
    enable = 1'b1;
    wait_falls(falls0 + 1, 600, "gated_start_timeout");
    wait_rises(5, 100, "gated_rise_timeout");
    enable = 1'b0;
    wait_strobes(6, 200, "gated_strobe_timeout");
    falls0 = cs_falls;
    repeat (1100) step();
    chk("disabled_cs_falls", cs_falls - falls0, 0);
    chk("disabled_strobes",  strobe_cnt, 6);

    // Reset asserted after the 7th SCLK rise aborts the frame; the next frame still decodes correctly.
    adc_q.push_back({3'b000, 12'hABC});
    enable = 1'b1;
    wait_falls(falls0 + 1, 600, "abort_start_timeout");
    wait_rises(7, 100, "abort_rise_timeout");
    #1 rst_n = 1'b0;
    #1;
    chk("abort_cs_n",   int'(cs_n_out),   1);
    chk("abort_sclk",   int'(sclk_out),   0);
    chk("abort_data",   int'(data_out),   0);
    chk("abort_ready",  int'(data_ready), 0);
    chk("abort_active", int'(active_out), 0);
    repeat (3) step();
    adc_q.push_back({3'b000, 12'h5A5}); exp_q.push_back(16'h5A50);
    rst_n = 1'b1;
    wait_strobes(7, 700, "recover_timeout");
    repeat (5) step();

    chk("scoreboard_left", exp_q.size(), 0);
    chk("final_overrun",   int'(overrun_out), 0);
    chk("invariant_errors", inv_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
